serial_issue_queue: RTL and testbench

SERIAL_ISSUE_QUEUE -- requirements
Module: serial_issue_queue

---
 rtl/serial_issue_queue_pkg.sv | 15 +
 rtl/serial_issue_queue_rob_age_compare.sv | 10 +
 rtl/serial_issue_queue.sv | 110 +++++++++++
 tb/tb_serial_issue_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_issue_queue_pkg.sv
// serial_issue_queue_pkg: shared entry status type, rob index type and rob age rule
package serial_issue_queue_pkg;
  localparam int PREG_W = 7;
  localparam int ROB_W = 6;
  typedef logic [ROB_W:0] rob_idx_t;
  typedef struct packed {
    logic we;
    logic [PREG_W-1:0] rs1;
    logic [PREG_W-1:0] rd;
    rob_idx_t rob_idx;
  } entry_t;
  function automatic logic is_younger(input rob_idx_t a, input rob_idx_t b);
    return (a[ROB_W] == b[ROB_W]) ? (a[ROB_W-1:0] > b[ROB_W-1:0]) : (a[ROB_W-1:0] < b[ROB_W-1:0]);
  endfunction
endpackage

// File: rtl/serial_issue_queue_rob_age_compare.sv
// rob_age_compare: younger is high when rob index a is strictly younger than b
module rob_age_compare
  import serial_issue_queue_pkg::*;
(
  input  rob_idx_t a,
  input  rob_idx_t b,
  output logic     younger
);
  assign younger = is_younger(a, b);
endmodule

// File: rtl/serial_issue_queue.sv
// serial_issue_queue: multi-lane enqueue, in-order single issue gated by commit, register read and wakeup handshakes
module serial_issue_queue
  import serial_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ENQ_WIDTH = 2,
  parameter int DATA_WIDTH = 64,
  parameter int PREG_WIDTH = PREG_W,
  parameter int ROB_WIDTH = ROB_W,
  parameter int XLEN = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ENQ_WIDTH-1:0]              enq_en,
  input  logic [ENQ_WIDTH-1:0]              enq_we,
  input  logic [ENQ_WIDTH*PREG_WIDTH-1:0]   enq_rs1,
  input  logic [ENQ_WIDTH*PREG_WIDTH-1:0]   enq_rd,
  input  logic [ENQ_WIDTH*(ROB_WIDTH+1)-1:0] enq_rob_idx,
  input  logic [ENQ_WIDTH*DATA_WIDTH-1:0]   enq_data,
  output logic                              enq_full,
  output logic [$clog2(DEPTH):0]            count,
  input  logic [ROB_WIDTH:0]                commit_rob_idx,
  input  logic                              redirect,
  input  logic [ROB_WIDTH:0]                redirect_idx,
  output logic                              reg_en,
  output logic [PREG_WIDTH-1:0]             reg_preg,
  input  logic                              reg_ready,
  input  logic [XLEN-1:0]                   reg_data,
  output logic                              wakeup_en,
  output logic                              wakeup_we,
  output logic [PREG_WIDTH-1:0]             wakeup_rd,
  input  logic                              wakeup_ready,
  output logic                              iss_valid,
  output logic [DATA_WIDTH-1:0]             iss_data,
  output logic                              iss_we,
  output logic [PREG_WIDTH-1:0]             iss_rd,
  output logic [ROB_WIDTH:0]                iss_rob_idx,
  output logic [XLEN-1:0]                   iss_rdata
);
  localparam int AW = $clog2(DEPTH);
  entry_t st_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [AW:0] head, tail, n_enq, keep_n;
  logic [AW:0] lane_ofs [ENQ_WIDTH];
  logic [AW-1:0] wr_idx [ENQ_WIDTH];
  logic [DEPTH-1:0] ent_younger;
  logic empty, enq_ok, sel, pop, iss_valid_q, iss_younger;
  entry_t head_ent;
  assign count = tail - head;
  assign empty = head == tail;
  assign enq_full = ((AW+1)'(DEPTH) - count) < (AW+1)'(ENQ_WIDTH);
  assign enq_ok = !enq_full && !redirect;
  assign head_ent = st_mem[head[AW-1:0]];
  assign sel = !empty && head_ent.rob_idx == commit_rob_idx && !redirect;
  assign reg_en = sel;
  assign reg_preg = head_ent.rs1;
  assign wakeup_en = sel && reg_ready;
  assign wakeup_we = head_ent.we;
  assign wakeup_rd = head_ent.rd;
  assign pop = wakeup_en && wakeup_ready;
  assign iss_valid = iss_valid_q && !(redirect && iss_younger);
  assign iss_rdata = reg_data;
  always_comb begin
    n_enq = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      lane_ofs[i] = n_enq;
      wr_idx[i] = tail[AW-1:0] + lane_ofs[i][AW-1:0];
      n_enq = n_enq + (AW+1)'(enq_en[i]);
    end
  end
  genvar k;
  for (k = 0; k < DEPTH; k++) begin : g_age
    rob_age_compare u_cmp (.a(st_mem[k].rob_idx), .b(redirect_idx), .younger(ent_younger[k]));
  end
  rob_age_compare u_iss_cmp (.a(iss_rob_idx), .b(redirect_idx), .younger(iss_younger));
  // surviving entries form a prefix from head, so counting them gives the new tail offset
  always_comb begin
    keep_n = '0;
    for (int j = 0; j < DEPTH; j++)
      if ({1'b0, AW'(j) - head[AW-1:0]} < count && !ent_younger[j]) keep_n = keep_n + (AW+1)'(1);
  end
  always_ff @(posedge clk)
    for (int i = 0; i < ENQ_WIDTH; i++)
      if (enq_ok && enq_en[i]) begin
        st_mem[wr_idx[i]] <= '{we: enq_we[i], rs1: enq_rs1[i*PREG_WIDTH +: PREG_WIDTH],
                               rd: enq_rd[i*PREG_WIDTH +: PREG_WIDTH],
                               rob_idx: enq_rob_idx[i*(ROB_WIDTH+1) +: ROB_WIDTH+1]};
        data_mem[wr_idx[i]] <= enq_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
  always_ff @(posedge clk)
    if (rst) begin
      head <= '0;
      tail <= '0;
      iss_valid_q <= 1'b0;
      iss_data <= '0;
      iss_we <= 1'b0;
      iss_rd <= '0;
      iss_rob_idx <= '0;
    end else begin
      head <= head + (AW+1)'(pop);
      tail <= redirect ? head + keep_n : tail + (enq_ok ? n_enq : '0);
      iss_valid_q <= pop;
      if (pop) begin
        iss_data <= data_mem[head[AW-1:0]];
        iss_we <= head_ent.we;
        iss_rd <= head_ent.rd;
        iss_rob_idx <= head_ent.rob_idx;
      end
    end
endmodule

// File: tb/tb_serial_issue_queue.sv
// tb_serial_issue_queue: directed checks of enqueue, commit-gated issue, redirect truncation and reset
module tb_serial_issue_queue;
  localparam int DEPTH = 4, EW = 2, DW = 64, PW = 7, RW = 6, XL = 64;
  logic clk = 1'b0, rst = 1'b1;
  logic [EW-1:0] enq_en = '0, enq_we = '0;
  logic [EW*PW-1:0] enq_rs1 = '0, enq_rd = '0;
  logic [EW*(RW+1)-1:0] enq_rob_idx = '0;
  logic [EW*DW-1:0] enq_data = '0;
  logic enq_full;
  logic [$clog2(DEPTH):0] count;
  logic [RW:0] commit_rob_idx = 7'h7f, redirect_idx = '0;
  logic redirect = 1'b0, reg_ready = 1'b1, wakeup_ready = 1'b1;
  logic [XL-1:0] reg_data = '0;
  logic reg_en, wakeup_en, wakeup_we, iss_valid, iss_we;
  logic [PW-1:0] reg_preg, wakeup_rd, iss_rd;
  logic [DW-1:0] iss_data;
  logic [RW:0] iss_rob_idx;
  logic [XL-1:0] iss_rdata;
  int checks = 0, errors = 0;
  serial_issue_queue #(.DEPTH(DEPTH), .ENQ_WIDTH(EW), .DATA_WIDTH(DW), .PREG_WIDTH(PW), .ROB_WIDTH(RW), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .enq_en(enq_en), .enq_we(enq_we), .enq_rs1(enq_rs1), .enq_rd(enq_rd),
    .enq_rob_idx(enq_rob_idx), .enq_data(enq_data), .enq_full(enq_full), .count(count),
    .commit_rob_idx(commit_rob_idx), .redirect(redirect), .redirect_idx(redirect_idx),
    .reg_en(reg_en), .reg_preg(reg_preg), .reg_ready(reg_ready), .reg_data(reg_data),
    .wakeup_en(wakeup_en), .wakeup_we(wakeup_we), .wakeup_rd(wakeup_rd), .wakeup_ready(wakeup_ready),
    .iss_valid(iss_valid), .iss_data(iss_data), .iss_we(iss_we), .iss_rd(iss_rd),
    .iss_rob_idx(iss_rob_idx), .iss_rdata(iss_rdata));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] dat(input int r);
    return 64'hD0D0_0000_0000_0000 + 64'(r);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic enq(input logic [1:0] m, input int a, input int b);
    enq_en = m;
    enq_we = {b[0], a[0]};
    enq_rs1 = {7'(b + 10), 7'(a + 10)};
    enq_rd = {7'(b + 20), 7'(a + 20)};
    enq_rob_idx = {7'(b), 7'(a)};
    enq_data = {dat(b), dat(a)};
  endtask
  task automatic push(input logic [1:0] m, input int a, input int b);
    enq(m, a, b);
    tick;
    enq_en = '0;
  endtask
  task automatic pop(input int r);
    commit_rob_idx = 7'(r);
    tick;
    commit_rob_idx = 7'h7f;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    enq_en = '0;
    redirect = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask
  initial begin
    do_reset;
    chk("rst_count", 64'(count), 0);
    chk("rst_full", 64'(enq_full), 0);
    chk("rst_iss_valid", 64'(iss_valid), 0);
    chk("rst_reg_en", 64'(reg_en), 0);
    push(2'b11, 3, 4);
    chk("enq1_count", 64'(count), 2);
    chk("enq1_full", 64'(enq_full), 0);
    push(2'b11, 5, 6);
    chk("enq2_count", 64'(count), 4);
    chk("enq2_full", 64'(enq_full), 1);
    push(2'b01, 7, 0);
    chk("full_ignored", 64'(count), 4);
    commit_rob_idx = 7'd2;
    #1 chk("nocommit_reg_en", 64'(reg_en), 0);
    commit_rob_idx = 7'd3;
    #1 chk("sel_reg_en", 64'(reg_en), 1);
    chk("sel_reg_preg", 64'(reg_preg), 13);
    chk("sel_wakeup_en", 64'(wakeup_en), 1);
    chk("sel_wakeup_rd", 64'(wakeup_rd), 23);
    chk("sel_wakeup_we", 64'(wakeup_we), 1);
    tick;
    commit_rob_idx = 7'h7f;
    reg_data = 64'h1234_5678_9ABC_DEF0;
    #1 chk("iss_valid", 64'(iss_valid), 1);
    chk("iss_rob", 64'(iss_rob_idx), 3);
    chk("iss_rd", 64'(iss_rd), 23);
    chk("iss_we", 64'(iss_we), 1);
    chk("iss_data", iss_data, dat(3));
    chk("iss_rdata", iss_rdata, 64'h1234_5678_9ABC_DEF0);
    chk("pop_count", 64'(count), 3);
    chk("pop_full", 64'(enq_full), 1);
    tick;
    chk("iss_idle", 64'(iss_valid), 0);
    do_reset;
    push(2'b11, 9, 10);
    pop(9);
    redirect = 1'b1;
    redirect_idx = 7'd8;
    enq(2'b01, 11, 0);
    #1 chk("kill_iss_valid", 64'(iss_valid), 0);
    redirect_idx = 7'd9;
    #1 chk("keep_iss_valid", 64'(iss_valid), 1);
    chk("keep_iss_rob", 64'(iss_rob_idx), 9);
    tick;
    redirect = 1'b0;
    enq_en = '0;
    chk("redir_b_count", 64'(count), 0);
    do_reset;
    push(2'b11, 2, 3);
    push(2'b11, 6, 7);
    redirect = 1'b1;
    redirect_idx = 7'd3;
    commit_rob_idx = 7'd2;
    enq(2'b11, 4, 5);
    #1 chk("redir_reg_en", 64'(reg_en), 0);
    tick;
    redirect = 1'b0;
    commit_rob_idx = 7'h7f;
    enq_en = '0;
    chk("redir_c_count", 64'(count), 2);
    chk("redir_c_full", 64'(enq_full), 0);
    push(2'b11, 4, 5);
    chk("refill_count", 64'(count), 4);
    pop(2);
    chk("order0", 64'(iss_rob_idx), 2);
    pop(3);
    chk("order1", 64'(iss_rob_idx), 3);
    pop(4);
    chk("order2", 64'(iss_rob_idx), 4);
    chk("order2_data", iss_data, dat(4));
    chk("order_count", 64'(count), 1);
    do_reset;
    push(2'b11, 1, 2);
    push(2'b10, 0, 3);
    chk("gap_count", 64'(count), 3);
    pop(1);
    pop(2);
    pop(3);
    chk("gap_rob", 64'(iss_rob_idx), 3);
    chk("gap_data", iss_data, dat(3));
    chk("gap_empty", 64'(count), 0);
    push(2'b11, 62, 65);
    chk("wrap_count", 64'(count), 2);
    chk("wrap_full", 64'(enq_full), 0);
    commit_rob_idx = 7'd62;
    wakeup_ready = 1'b0;
    #1 chk("wr0_reg_en", 64'(reg_en), 1);
    chk("wr0_reg_preg", 64'(reg_preg), 72);
    chk("wr0_wakeup_en", 64'(wakeup_en), 1);
    tick;
    chk("nopop_count", 64'(count), 2);
    chk("nopop_iss", 64'(iss_valid), 0);
    reg_ready = 1'b0;
    #1 chk("rr0_wakeup_en", 64'(wakeup_en), 0);
    chk("rr0_reg_en", 64'(reg_en), 1);
    reg_ready = 1'b1;
    wakeup_ready = 1'b1;
    commit_rob_idx = 7'h7f;
    push(2'b11, 66, 67);
    chk("wrap_fill_count", 64'(count), 4);
    chk("wrap_fill_full", 64'(enq_full), 1);
    redirect = 1'b1;
    redirect_idx = 7'd62;
    tick;
    redirect = 1'b0;
    chk("dir_redir_count", 64'(count), 1);
    pop(62);
    chk("dir_iss_rob", 64'(iss_rob_idx), 62);
    chk("dir_iss_data", iss_data, dat(62));
    chk("dir_count", 64'(count), 0);
    do_reset;
    push(2'b11, 1, 2);
    commit_rob_idx = 7'd1;
    enq(2'b11, 3, 4);
    tick;
    commit_rob_idx = 7'h7f;
    enq_en = '0;
    chk("same_cyc_count", 64'(count), 3);
    chk("same_cyc_iss", 64'(iss_valid), 1);
    chk("same_cyc_rob", 64'(iss_rob_idx), 1);
    rst = 1'b1;
    tick;
    chk("mid_rst_count", 64'(count), 0);
    chk("mid_rst_iss", 64'(iss_valid), 0);
    chk("mid_rst_full", 64'(enq_full), 0);
    chk("mid_rst_rob", 64'(iss_rob_idx), 0);
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
